// File: rtl/bemf_sched_if.sv
// Handshake bundle between the back-EMF scheduler, the ADC controller and the bemf_update pipeline.
interface bemf_sched_if;
    logic        adc_req;
    logic [3:0]  adc_chan;
    logic        adc_ack;
    logic [9:0]  adc_data;
    logic [9:0]  bu_adc_h;
    logic [9:0]  bu_adc_l;
    logic [1:0]  bu_mot_sel;
    logic        bu_in_valid;
    logic [19:0] bu_bemf_in;
    logic [19:0] bu_calib;
    logic [19:0] bu_bemf_out;
    logic [1:0]  bu_mot_sel_out;
    logic        bu_out_valid;

    modport master (
        output adc_req, adc_chan, bu_adc_h, bu_adc_l, bu_mot_sel, bu_in_valid, bu_bemf_in, bu_calib,
        input  adc_ack, adc_data, bu_bemf_out, bu_mot_sel_out, bu_out_valid
    );

    modport slave (
        input  adc_req, adc_chan, bu_adc_h, bu_adc_l, bu_mot_sel, bu_in_valid, bu_bemf_in, bu_calib,
        output adc_ack, adc_data, bu_bemf_out, bu_mot_sel_out, bu_out_valid
    );
endinterface

// File: rtl/bemf_sched.sv
// Round-robin back-EMF scheduler: waits out each motor's coast window, samples high/low
// ADC channels, pushes one bemf_update transaction and writes the result back.
module bemf_sched #(
    parameter int SETTLE_CYCLES  = 500,
    parameter int RESULT_TIMEOUT = 15,
    parameter int CHAN_BASE      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [3:0]          coast,
    input  logic [3:0]          clr,
    input  logic [79:0]         calib,
    bemf_sched_if.master        bus,
    output logic [79:0]         bemf_acc,
    output logic [3:0]          upd,
    output logic                busy
);
    localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = (RESULT_TIMEOUT > 2) ? $clog2(RESULT_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    // WAIT_RES lasts RESULT_TIMEOUT-1 cycles so NEXT lands RESULT_TIMEOUT cycles after ISSUE
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESULT_TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        REQ_H    = 3'd2,
        REQ_L    = 3'd3,
        ISSUE    = 3'd4,
        WAIT_RES = 3'd5,
        NEXT     = 3'd6
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [1:0]         ptr_r, ptr_nxt_s;
    logic [SET_W-1:0]   set_cnt_r, set_cnt_nxt_s;
    logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
    logic               ack_s, wr_s;
    logic [3:0]         wr_mask_s;
    logic [3:0]         chan_h_s, chan_l_s;
    logic [3:0][19:0]   calib_s;
    logic [3:0][19:0]   acc_r;
    logic [9:0]         lat_h_r;
    logic               adc_req_r, bu_in_valid_r, busy_r;
    logic [3:0]         adc_chan_r, upd_r;
    logic [9:0]         bu_adc_h_r, bu_adc_l_r;
    logic [1:0]         bu_mot_sel_r;
    logic [19:0]        bu_bemf_in_r, bu_calib_r;

    assign calib_s   = calib;
    assign ack_s     = bus.adc_ack & adc_req_r;
    assign chan_h_s  = 4'(CHAN_BASE) + {1'b0, ptr_r, 1'b0};
    assign chan_l_s  = chan_h_s + 4'd1;
    assign wr_mask_s = wr_s ? (4'b0001 << ptr_r) : 4'b0000;

    // Next-state, pointer and counter logic
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        set_cnt_nxt_s = set_cnt_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        wr_s          = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt_s = SETTLE;
                else        state_nxt_s = IDLE;
            end
            SETTLE: begin
                if (!coast[ptr_r]) begin
                    set_cnt_nxt_s = '0;
                    state_nxt_s   = NEXT;
                end else if (set_cnt_r == SET_LAST) begin
                    set_cnt_nxt_s = '0;
                    state_nxt_s   = REQ_H;
                end else begin
                    set_cnt_nxt_s = set_cnt_r + 1'b1;
                end
            end
            REQ_H: begin
                if (ack_s) state_nxt_s = REQ_L;
                else       state_nxt_s = REQ_H;
            end
            REQ_L: begin
                if (ack_s) state_nxt_s = ISSUE;
                else       state_nxt_s = REQ_L;
            end
            ISSUE: begin
                tmo_cnt_nxt_s = '0;
                state_nxt_s   = WAIT_RES;
            end
            WAIT_RES: begin
                // A result tagged for another motor is dropped; only the timeout moves on
                if (bus.bu_out_valid && (bus.bu_mot_sel_out == ptr_r)) begin
                    wr_s        = 1'b1;
                    state_nxt_s = NEXT;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = NEXT;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + 1'b1;
                end
            end
            NEXT: begin
                ptr_nxt_s = ptr_r + 2'd1;
                if (enable) state_nxt_s = SETTLE;
                else        state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, motor pointer and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= 2'd0;
            set_cnt_r <= '0;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            set_cnt_r <= set_cnt_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
        end
    end

    // Registered ADC and pipeline outputs, driven from the upcoming state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_req_r     <= 1'b0;
            adc_chan_r    <= 4'd0;
            lat_h_r       <= 10'd0;
            bu_adc_h_r    <= 10'd0;
            bu_adc_l_r    <= 10'd0;
            bu_mot_sel_r  <= 2'd0;
            bu_in_valid_r <= 1'b0;
            bu_bemf_in_r  <= 20'd0;
            bu_calib_r    <= 20'd0;
            busy_r        <= 1'b0;
        end else begin
            adc_req_r     <= (state_nxt_s == REQ_H) || (state_nxt_s == REQ_L);
            bu_in_valid_r <= (state_nxt_s == ISSUE);
            busy_r        <= (state_nxt_s != IDLE);
            if (state_nxt_s == REQ_H)      adc_chan_r <= chan_h_s;
            else if (state_nxt_s == REQ_L) adc_chan_r <= chan_l_s;
            else                           adc_chan_r <= adc_chan_r;
            if ((state_r == REQ_H) && ack_s) lat_h_r <= bus.adc_data;
            else                             lat_h_r <= lat_h_r;
            // The low-side sample is latched straight into its output on the ISSUE edge
            if ((state_r == REQ_L) && ack_s) begin
                bu_adc_h_r   <= lat_h_r;
                bu_adc_l_r   <= bus.adc_data;
                bu_mot_sel_r <= ptr_r;
                bu_bemf_in_r <= acc_r[ptr_r];
                bu_calib_r   <= calib_s[ptr_r];
            end else begin
                bu_adc_h_r   <= bu_adc_h_r;
                bu_adc_l_r   <= bu_adc_l_r;
                bu_mot_sel_r <= bu_mot_sel_r;
                bu_bemf_in_r <= bu_bemf_in_r;
                bu_calib_r   <= bu_calib_r;
            end
        end
    end

    // Accumulator write-back; a host clear overrides a same-cycle result but upd still pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            upd_r <= 4'd0;
        end else begin
            upd_r <= wr_mask_s;
            for (int m = 0; m < 4; m++) begin
                if (clr[m])            acc_r[m] <= 20'd0;
                else if (wr_mask_s[m]) acc_r[m] <= bus.bu_bemf_out;
                else                   acc_r[m] <= acc_r[m];
            end
        end
    end

    assign bus.adc_req     = adc_req_r;
    assign bus.adc_chan    = adc_chan_r;
    assign bus.bu_adc_h    = bu_adc_h_r;
    assign bus.bu_adc_l    = bu_adc_l_r;
    assign bus.bu_mot_sel  = bu_mot_sel_r;
    assign bus.bu_in_valid = bu_in_valid_r;
    assign bus.bu_bemf_in  = bu_bemf_in_r;
    assign bus.bu_calib    = bu_calib_r;
    assign bemf_acc        = acc_r;
    assign upd             = upd_r;
    assign busy            = busy_r;
endmodule
